// File: rtl/rv_rom_loader_pkg.sv
// Shared loader definitions: FSM state encoding, frame sync marker and
// default ROM geometry used by rv_rom_loader and its packer.
package rv_rom_loader_pkg;

    localparam int unsigned DEF_ADDR_W    = 12;
    localparam int unsigned DEF_ROM_DEPTH = 4096;
    localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

endpackage

// File: rtl/rv_rom_loader_pack.sv
// Byte-to-word packer: assembles four consecutive bytes little-endian and
// flags the byte that completes a word, presenting the full word combinationally.
module rv_loader_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            case (r_cnt)
                2'd0:    r_word[7:0]   <= i_byte;
                2'd1:    r_word[15:8]  <= i_byte;
                2'd2:    r_word[23:16] <= i_byte;
                default: ;
            endcase
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // The 4th byte is never stored: it goes straight into the output word.
    assign o_word_done = i_valid && (r_cnt == 2'd3);
    assign o_word      = {i_byte, r_word};

endmodule

// File: rtl/rv_rom_loader.sv
// Boot ROM loader: parses a sync/length/data/checksum byte frame, writes the
// payload words into the instruction ROM and releases the core on success.
module rv_rom_loader
    import rv_rom_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned ROM_DEPTH = DEF_ROM_DEPTH,
    parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    // Wide enough to hold ROM_DEPTH itself, so a full-depth load never wraps.
    localparam int unsigned CNT_W = $clog2(ROM_DEPTH + 1);

    ldr_state_t        r_state;
    ldr_state_t        w_next;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_widx;
    logic [7:0]        r_csum;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_xfer;
    logic              w_pack_valid;
    logic              w_word_done;
    logic [31:0]       w_word;
    logic              w_len_bad;
    logic              w_last_word;

    assign w_xfer       = rx_valid && rx_ready;
    assign w_pack_valid = w_xfer && ((r_state == ST_LEN) || (r_state == ST_DATA));
    assign w_len_bad    = (w_word == '0) || (w_word > 32'(ROM_DEPTH));
    assign w_last_word  = (r_widx == r_len - CNT_W'(1));

    rv_loader_pack u_pack (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_pack_valid),
        .i_byte      (rx_data),
        .o_word_done (w_word_done),
        .o_word      (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        rx_ready  = 1'b0;
        core_hold = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (w_xfer && (rx_data == SYNC_BYTE)) w_next = ST_LEN;
            end
            ST_LEN: begin
                rx_ready = 1'b1;
                if (w_word_done) w_next = w_len_bad ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (w_word_done && w_last_word) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                rx_ready = 1'b1;
                if (w_xfer) w_next = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                core_hold = 1'b0;
                load_done = 1'b1;
            end
            ST_ERR: begin
                load_err = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len   <= '0;
            r_widx  <= '0;
            r_csum  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if ((r_state == ST_LEN) && w_word_done) begin
                r_len <= CNT_W'(w_word);
            end
            if ((r_state == ST_DATA) && w_pack_valid) begin
                r_csum <= r_csum ^ rx_data;
            end
            if ((r_state == ST_DATA) && w_word_done) begin
                r_we    <= 1'b1;
                r_addr  <= ADDR_W'(r_widx);
                r_wdata <= w_word;
                r_widx  <= r_widx + CNT_W'(1);
            end
        end
    end

    assign rom_we    = r_we;
    assign rom_addr  = r_addr;
    assign rom_wdata = r_wdata;

endmodule

// File: tb/tb_rv_rom_loader.sv
// Randomized scoreboard bench for rv_rom_loader: frames are parsed by a
// byte-level reference model, expected ROM writes are queued and matched by a monitor.
module tb_rv_rom_loader;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4096;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_err;

    rv_rom_loader #(
        .ADDR_W    (AW),
        .ROM_DEPTH (DEPTH),
        .SYNC_BYTE (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .core_hold (core_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  fq[$];
    int          m_tag[$];
    logic [31:0] m_word[$];
    bit          m_done;
    bit          m_err;
    int          m_nacc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each ROM write must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rom_write: unexpected write addr=%h data=%h cyc=%0d", rom_addr, rom_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (rom_addr !== AW'(mon_e.addr) || rom_wdata !== mon_e.data || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL rom_write: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                             rom_addr, rom_wdata, cyc, AW'(mon_e.addr), mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic build_frame(input int unsigned nlen, input int nwords, input bit fixed,
                               input bit bad, input bit garbage);
        logic [7:0]  x;
        logic [31:0] w;
        fq.delete();
        x = 8'h00;
        if (garbage) begin
            fq.push_back(8'h00);
            fq.push_back(8'hFF);
        end
        fq.push_back(SYNC);
        fq.push_back(nlen[7:0]);
        fq.push_back(nlen[15:8]);
        fq.push_back(nlen[23:16]);
        fq.push_back(nlen[31:24]);
        for (int k = 0; k < nwords; k++) begin
            w = fixed ? 32'h0000_0013 : $urandom;
            for (int b = 0; b < 4; b++) begin
                fq.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
        fq.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    // Reference parse of the byte stream: what gets accepted, which byte completes which word.
    task automatic model();
        int          p;
        int unsigned n;
        logic [7:0]  x;
        m_tag.delete();
        m_word.delete();
        for (int i = 0; i < fq.size(); i++) m_tag.push_back(-1);
        p = 0;
        while (fq[p] != SYNC) p++;
        n = {fq[p+4], fq[p+3], fq[p+2], fq[p+1]};
        if (n == 0 || n > DEPTH) begin
            m_nacc = p + 5;
            m_done = 1'b0;
            m_err  = 1'b1;
        end else begin
            x = 8'h00;
            for (int k = 0; k < int'(n); k++) begin
                m_word.push_back({fq[p+5+4*k+3], fq[p+5+4*k+2], fq[p+5+4*k+1], fq[p+5+4*k]});
                for (int b = 0; b < 4; b++) x = x ^ fq[p+5+4*k+b];
                m_tag[p+5+4*k+3] = k;
            end
            m_nacc = p + 5 + 4 * int'(n) + 1;
            m_done = (fq[m_nacc-1] == x);
            m_err  = !m_done;
        end
    endtask

    task automatic send_frame(input string name, input int max_gap);
        model();
        for (int i = 0; i < m_nacc; i++) begin
            repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = fq[i];
            if (rx_ready !== 1'b1) check({name, ".rx_ready"}, {31'b0, rx_ready}, 32'd1);
            if (m_tag[i] >= 0) exp_q.push_back('{m_tag[i], m_word[m_tag[i]], cyc + 1});
            @(negedge clk);
        end
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({name, ".load_done"}, {31'b0, load_done}, {31'b0, m_done});
        check({name, ".load_err"},  {31'b0, load_err},  {31'b0, m_err});
        check({name, ".core_hold"}, {31'b0, core_hold}, {31'b0, !m_done});
        check({name, ".rx_ready"},  {31'b0, rx_ready},  32'd0);
        check({name, ".pending_writes"}, exp_q.size(), 32'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset.rx_ready",  {31'b0, rx_ready},  32'd1);
        check("reset.rom_we",    {31'b0, rom_we},    32'd0);
        check("reset.rom_addr",  {20'b0, rom_addr},  32'd0);
        check("reset.rom_wdata", rom_wdata,          32'd0);
        check("reset.core_hold", {31'b0, core_hold}, 32'd1);
        check("reset.load_done", {31'b0, load_done}, 32'd0);
        check("reset.load_err",  {31'b0, load_err},  32'd0);
        rst = 1'b0;

        build_frame(1, 1, 1'b1, 1'b0, 1'b0);
        send_frame("single_word", 2);

        reset_dut();
        build_frame(1, 1, 1'b1, 1'b1, 1'b0);
        send_frame("bad_checksum", 2);

        reset_dut();
        build_frame(0, 0, 1'b0, 1'b0, 1'b0);
        send_frame("len_zero", 1);

        reset_dut();
        build_frame(DEPTH + 1, 0, 1'b0, 1'b0, 1'b0);
        send_frame("len_over", 1);

        reset_dut();
        build_frame(3, 3, 1'b0, 1'b0, 1'b1);
        send_frame("garbage_prefix", 3);

        reset_dut();
        build_frame(3, 3, 1'b0, 1'b0, 1'b0);
        send_frame("back_to_back", 0);

        // Abort after two data bytes: nothing from this frame may reach the ROM.
        reset_dut();
        build_frame(2, 2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            rx_valid = 1'b1;
            rx_data  = fq[i];
            @(negedge clk);
        end
        reset_dut();
        build_frame(2, 2, 1'b0, 1'b0, 1'b0);
        send_frame("after_abort", 1);

        for (int f = 0; f < 8; f++) begin
            reset_dut();
            build_frame($urandom_range(1, 6), 0, 1'b0, 1'b0, 1'b0);
            fq.delete();
            begin
                int unsigned n;
                n = $urandom_range(1, 6);
                build_frame(n, int'(n), 1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            end
            send_frame("random", 3);
        end

        reset_dut();
        build_frame(DEPTH, DEPTH, 1'b0, 1'b0, 1'b0);
        send_frame("full_depth", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
